// File: rtl/spi2adc.sv
// SPI master for the MCP3002 10-bit ADC: one 16-SCK frame per conversion, result plus one-cycle strobe.
// Define SPI2ADC_AUTO_EN for free-running conversions (start ignored, frames back to back).
module spi2adc #(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  input  logic       channel,
  input  logic       adc_dout,
  output logic       adc_cs,
  output logic       adc_sck,
  output logic       adc_din,
  output logic [9:0] data_from_adc,
  output logic       data_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic        ch_q;
  logic [9:0]  sreg;
  logic [15:0] tx;
  logic        launch;
  logic        div_done;

  // Config word: leading zero, start, single-ended, channel, MSB-first, then don't-care zeros
  assign tx       = {3'b011, ch_q, 1'b1, 11'b0};
  assign div_done = (div_cnt == DIV_LAST);

`ifdef SPI2ADC_AUTO_EN
  // Free-running: leave reset straight into a frame and chain frames at the end of GAP
  assign launch = (state == IDLE) || ((state == GAP) && div_done);
`else
  assign launch = (state == IDLE) && start;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      ch_q          <= 1'b0;
      sreg          <= '0;
      adc_cs        <= 1'b1;
      adc_sck       <= 1'b0;
      adc_din       <= 1'b0;
      data_from_adc <= '0;
      data_valid    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (launch) begin
        state   <= SHIFT;
        ch_q    <= channel;
        div_cnt <= '0;
        bit_cnt <= '0;
        sreg    <= '0;
        adc_cs  <= 1'b0;
        adc_sck <= 1'b0;
        adc_din <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (!div_done) begin
              div_cnt <= div_cnt + 8'd1;
            end else begin
              div_cnt <= '0;
              if (!adc_sck) begin
                adc_sck <= 1'b1;
                // Bits 0..5 carry config and the null bit; only 6..15 hold D9..D0
                if (bit_cnt >= 4'd6) sreg <= {sreg[8:0], adc_dout};
              end else if (bit_cnt == 4'd15) begin
                state         <= GAP;
                adc_cs        <= 1'b1;
                adc_sck       <= 1'b0;
                adc_din       <= 1'b0;
                data_from_adc <= sreg;
                data_valid    <= 1'b1;
              end else begin
                adc_sck <= 1'b0;
                bit_cnt <= bit_cnt + 4'd1;
                adc_din <= tx[4'd14 - bit_cnt];
              end
            end
          end
          GAP: begin
            if (!div_done) begin
              div_cnt <= div_cnt + 8'd1;
            end else begin
              div_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi2adc.sv
// Bench for spi2adc: two instances (CLK_DIV=2 and 25), each with a behavioural MCP3002 model.
module tb_spi2adc;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, channel, dout, cs, sck, din, valid, busy;
  logic [9:0] dfa [2];

  logic [9:0]  mval  [2];
  logic [15:0] rxdin [2];
  int          rises [2];
  int          nbit  [2];
  logic        auto_inc;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : 25;
    spi2adc #(.CLK_DIV(D)) u_dut (
      .sysclk(clk), .reset(rst), .start(start[g]), .channel(channel[g]),
      .adc_dout(dout[g]), .adc_cs(cs[g]), .adc_sck(sck[g]), .adc_din(din[g]),
      .data_from_adc(dfa[g]), .data_valid(valid[g]), .busy(busy[g])
    );

    // ADC model: null bit after 5 config bits, then D9..D0 driven on falling SCK
    always @(negedge cs[g]) begin
      nbit[g]  = 0;
      rises[g] = 0;
      rxdin[g] = '0;
      dout[g]  = 1'b0;
    end
    always @(posedge sck[g]) if (!cs[g]) begin
      rises[g]++;
      rxdin[g] = {rxdin[g][14:0], din[g]};
    end
    always @(negedge sck[g]) if (!cs[g]) begin
      logic [9:0] v;
      v = mval[g];
      nbit[g]++;
      dout[g] = (nbit[g] >= 6 && nbit[g] <= 15) ? v[15 - nbit[g]] : 1'b0;
    end
    always @(posedge cs[g]) if (auto_inc) mval[g] = mval[g] + 10'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input int i, input logic ch, input logic [9:0] v,
                           input logic [15:0] exp_din, input int d, input string tag);
    int n, m;
    mval[i] = v;
    @(negedge clk);
    start[i]   = 1'b1;
    channel[i] = ch;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start[i]   = 1'b0;
        channel[i] = ~ch;
      end
    end while (!valid[i] && n < 5000);
    chk({tag, " latency"}, n, 32 * d + 1);
    chk({tag, " data"}, dfa[i], v);
    chk({tag, " din bits"}, rxdin[i], exp_din);
    chk({tag, " sck rises"}, rises[i], 16);
    chk({tag, " cs high at valid"}, cs[i], 1);
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
      if (m == 1) chk({tag, " valid one cycle"}, valid[i], 0);
    end while (busy[i] && m < 1000);
    chk({tag, " busy fall"}, m, d);
    chk({tag, " data held"}, dfa[i], v);
  endtask

  typedef struct {
    logic        ch;
    logic [9:0]  val;
    logic [15:0] exp_din;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int   t [3];
    int   k, cyc;

    tbl[0] = '{1'b0, 10'h2A5, 16'h6800};
    tbl[1] = '{1'b1, 10'h3FF, 16'h7800};
    tbl[2] = '{1'b1, 10'h000, 16'h7800};
    tbl[3] = '{1'b0, 10'h155, 16'h6800};

    rst = 1'b1; start = '0; channel = '0; dout = '0; auto_inc = 1'b0;
    mval[0] = '0; mval[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs", cs, 2'b11);
    chk("reset sck", sck, 2'b00);
    chk("reset din", din, 2'b00);
    chk("reset valid", valid, 2'b00);
    chk("reset busy", busy, 2'b00);
    chk("reset data", dfa[0], 0);

`ifdef SPI2ADC_AUTO_EN
    mval[0]  = 10'h100;
    auto_inc = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0; k = 0;
    while (k < 3 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (valid[0]) begin
        t[k] = cyc;
        chk("auto data", dfa[0], 10'h100 + 10'(k));
        k++;
      end
      if (cyc > 1) chk("auto busy", busy[0], 1);
    end
    chk("auto frames seen", k, 3);
    chk("auto first latency", t[0], 65);
    chk("auto period 1", t[1] - t[0], 66);
    chk("auto period 2", t[2] - t[1], 66);
`else
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      run_frame(0, tbl[i].ch, tbl[i].val, tbl[i].exp_din, 2, $sformatf("vec%0d", i));

    // start held high: IDLE re-accepts one cycle after GAP ends
    mval[0] = 10'h0F0;
    @(negedge clk);
    start[0] = 1'b1;
    cyc = 0; k = 0;
    while (k < 3 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (valid[0]) begin
        t[k] = cyc;
        k++;
      end
    end
    start[0] = 1'b0;
    chk("held frames seen", k, 3);
    chk("held first latency", t[0], 65);
    chk("held period 1", t[1] - t[0], 67);
    chk("held period 2", t[2] - t[1], 67);
    chk("held data", dfa[0], 10'h0F0);
    k = 0;
    while (busy[0] && k < 200) begin @(posedge clk); #1; k++; end
    chk("held busy drains", busy[0], 0);

    // Reset mid-frame during bit 8
    mval[0] = 10'h2C3;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (33) @(posedge clk);
    #2;
    chk("pre-reset rises", rises[0], 8);
    rst = 1'b1;
    #1;
    chk("midreset cs", cs[0], 1);
    chk("midreset sck", sck[0], 0);
    chk("midreset busy", busy[0], 0);
    chk("midreset data", dfa[0], 0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (100) begin @(posedge clk); #1; if (valid[0]) k++; end
    chk("no valid after reset", k, 0);
    chk("data after reset", dfa[0], 0);
    run_frame(0, 1'b0, 10'h2C3, 16'h6800, 2, "post-reset");

    run_frame(1, 1'b1, 10'h1C3, 16'h7800, 25, "div25");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
